// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: EXE-stage ALU/MDU opcodes and multiply/divide kind encoding.
// Shared by alu_mdu (top) and mdu_iter (iterative multiply/divide datapath).
package alu_mdu_pkg;

   localparam logic [4:0] EXE_ALU_ADD   = 5'd0;
   localparam logic [4:0] EXE_ALU_SUB   = 5'd1;
   localparam logic [4:0] EXE_ALU_AND   = 5'd2;
   localparam logic [4:0] EXE_ALU_OR    = 5'd3;
   localparam logic [4:0] EXE_ALU_XOR   = 5'd4;
   localparam logic [4:0] EXE_ALU_NOR   = 5'd5;
   localparam logic [4:0] EXE_ALU_SLT   = 5'd6;
   localparam logic [4:0] EXE_ALU_SLTU  = 5'd7;
   localparam logic [4:0] EXE_ALU_SLL   = 5'd8;
   localparam logic [4:0] EXE_ALU_SRL   = 5'd9;
   localparam logic [4:0] EXE_ALU_SRA   = 5'd10;
   localparam logic [4:0] EXE_ALU_SLLV  = 5'd11;
   localparam logic [4:0] EXE_ALU_SRLV  = 5'd12;
   localparam logic [4:0] EXE_ALU_SRAV  = 5'd13;
   localparam logic [4:0] EXE_ALU_LUI   = 5'd14;
   localparam logic [4:0] EXE_ALU_MULT  = 5'd15;
   localparam logic [4:0] EXE_ALU_MULTU = 5'd16;
   localparam logic [4:0] EXE_ALU_DIV   = 5'd17;
   localparam logic [4:0] EXE_ALU_DIVU  = 5'd18;
   localparam logic [4:0] EXE_ALU_MFHI  = 5'd19;
   localparam logic [4:0] EXE_ALU_MFLO  = 5'd20;
   localparam logic [4:0] EXE_ALU_MTHI  = 5'd21;
   localparam logic [4:0] EXE_ALU_MTLO  = 5'd22;

   typedef enum logic [1:0] {
      MduMult  = 2'd0,
      MduMultu = 2'd1,
      MduDiv   = 2'd2,
      MduDivu  = 2'd3
   } mdu_kind_e;

   function automatic logic is_mdu_op(input logic [4:0] op);
      return (op == EXE_ALU_MULT) || (op == EXE_ALU_MULTU) ||
             (op == EXE_ALU_DIV)  || (op == EXE_ALU_DIVU);
   endfunction

   function automatic mdu_kind_e mdu_kind(input logic [4:0] op);
      case (op)
         EXE_ALU_MULTU: return MduMultu;
         EXE_ALU_DIV:   return MduDiv;
         EXE_ALU_DIVU:  return MduDivu;
         default:       return MduMult;
      endcase
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply (shift-add) / divide (restoring), one bit per clock.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         abort an operation in flight (no done)
//   start         begin an operation (only honoured when idle)
//   kind          mdu_kind_e encoding: MULT, MULTU, DIV, DIVU
//   a, b          operands, sampled on the start edge
//   idle          no operation in flight
//   done          asserted in the FIX state; hi/lo carry the final values
//   hi, lo        product {hi,lo} or remainder/quotient, sign-corrected
module mdu_iter import alu_mdu_pkg::*; #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic [1:0]       kind,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             idle,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   // Multiply: {acc_hi,acc_lo} is the partial product / multiplier.
   // Divide: acc_hi is the partial remainder, acc_lo the dividend/quotient.
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             div0_q, div0_d;
   logic             isdiv_q, isdiv_d;

   mdu_kind_e        kind_e;
   logic             is_signed, is_div, a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   msum;
   logic [WIDTH:0]   dshift;
   logic [WIDTH+1:0] ddiff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign kind_e    = mdu_kind_e'(kind);
   assign is_signed = (kind_e == MduMult) || (kind_e == MduDiv);
   assign is_div    = (kind_e == MduDiv) || (kind_e == MduDivu);
   assign a_neg     = is_signed & a[WIDTH-1];
   assign b_neg     = is_signed & b[WIDTH-1];
   assign a_abs     = a_neg ? -a : a;
   assign b_abs     = b_neg ? -b : b;

   assign msum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
   assign dshift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign ddiff  = {1'b0, dshift} - {2'b00, opnd_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         div0_q   <= 1'b0;
         isdiv_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         div0_q   <= div0_d;
         isdiv_q  <= isdiv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      div0_d   = div0_q;
      isdiv_d  = isdiv_q;
      unique case (state_q)
         StIdle: begin
            if (start && !flush) begin
               cnt_d    = CntW'(WIDTH);
               acc_hi_d = '0;
               acc_lo_d = is_div ? a_abs : b_abs;
               opnd_d   = is_div ? b_abs : a_abs;
               negq_d   = a_neg ^ b_neg;
               negr_d   = a_neg;
               div0_d   = (b == '0);
               isdiv_d  = is_div;
               state_d  = is_div ? StDiv : StMul;
            end
         end
         StMul: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               {acc_hi_d, acc_lo_d} = {msum, acc_lo_q[WIDTH-1:1]};
               cnt_d = cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) state_d = StFix;
            end
         end
         StDiv: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               // Non-negative trial difference means the divisor fits: quotient bit 1.
               if (!ddiff[WIDTH+1]) begin
                  acc_hi_d = ddiff[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi_d = dshift[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) state_d = StFix;
            end
         end
         StFix: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign prod_fix = negq_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
   assign quot_fix = negq_q ? -acc_lo_q : acc_lo_q;
   // Divide by zero leaves |a| in the remainder; the remainder sign fix restores a.
   assign rem_fix  = negr_q ? -acc_hi_q : acc_hi_q;

   assign idle = (state_q == StIdle);
   assign done = (state_q == StFix) && !flush;
   assign hi   = isdiv_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
   assign lo   = isdiv_q ? (div0_q ? '1 : quot_fix) : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered EXE-stage ALU with iterative multiply/divide into HI/LO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           abort in-flight multicycle op; blocks acceptance when idle
//   in_valid        operation presented
//   in_ready        unit idle and able to accept
//   oper, a, b      opcode (EXE_ALU_*), operand A / shift amount, operand B / shifted value
//   out_valid       one-cycle pulse when result or HI/LO updated
//   result          registered single-cycle result
//   hi, lo          HI/LO registers
//   busy            ~in_ready
module alu_mdu import alu_mdu_pkg::*; #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       oper,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy
);

   logic [WIDTH-1:0] result_q, hi_q, lo_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] alu_res;
   logic [SHAMT_W-1:0] shamt;
   logic             accept, acc_single, acc_mdu;
   logic             iter_idle, iter_done;
   logic [WIDTH-1:0] iter_hi, iter_lo;
   logic [1:0]       kind_sel;

   assign accept     = in_valid && in_ready && !flush;
   assign acc_mdu    = accept && is_mdu_op(oper);
   assign acc_single = accept && !is_mdu_op(oper);
   assign kind_sel   = mdu_kind(oper);
   assign shamt      = a[SHAMT_W-1:0];

   mdu_iter #(
      .WIDTH(WIDTH)
   ) u_mdu_iter (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .start (acc_mdu),
      .kind  (kind_sel),
      .a     (a),
      .b     (b),
      .idle  (iter_idle),
      .done  (iter_done),
      .hi    (iter_hi),
      .lo    (iter_lo)
   );

   always_comb begin
      alu_res = '0;
      case (oper)
         EXE_ALU_ADD:  alu_res = a + b;
         EXE_ALU_SUB:  alu_res = a - b;
         EXE_ALU_AND:  alu_res = a & b;
         EXE_ALU_OR:   alu_res = a | b;
         EXE_ALU_XOR:  alu_res = a ^ b;
         EXE_ALU_NOR:  alu_res = ~(a | b);
         EXE_ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         EXE_ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         EXE_ALU_SLL,
         EXE_ALU_SLLV: alu_res = b << shamt;
         EXE_ALU_SRL,
         EXE_ALU_SRLV: alu_res = b >> shamt;
         EXE_ALU_SRA,
         EXE_ALU_SRAV: alu_res = WIDTH'($signed(b) >>> shamt);
         EXE_ALU_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         EXE_ALU_MFHI: alu_res = hi_q;
         EXE_ALU_MFLO: alu_res = lo_q;
         // Moves to HI/LO leave the result register untouched.
         EXE_ALU_MTHI,
         EXE_ALU_MTLO: alu_res = result_q;
         default:      alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q    <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (acc_single) begin
            result_q    <= alu_res;
            out_valid_q <= 1'b1;
            if (oper == EXE_ALU_MTHI) hi_q <= a;
            if (oper == EXE_ALU_MTLO) lo_q <= a;
         end
         if (iter_done) begin
            hi_q        <= iter_hi;
            lo_q        <= iter_lo;
            out_valid_q <= 1'b1;
         end
      end
   end

   assign in_ready  = iter_idle;
   assign busy      = ~iter_idle;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
   import alu_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [4:0]  oper = 5'd0;
   logic [31:0] a = '0, b = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] result, hi, lo;

   logic        w16_flush = 1'b0;
   logic        w16_in_valid = 1'b0;
   logic [4:0]  w16_oper = 5'd0;
   logic [15:0] w16_a = '0, w16_b = '0;
   logic        w16_in_ready, w16_out_valid, w16_busy;
   logic [15:0] w16_result, w16_hi, w16_lo;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .oper(oper), .a(a), .b(b), .out_valid(out_valid), .result(result),
      .hi(hi), .lo(lo), .busy(busy)
   );

   alu_mdu #(.WIDTH(16), .SHAMT_W(4)) dut16 (
      .clk(clk), .rst(rst), .flush(w16_flush), .in_valid(w16_in_valid),
      .in_ready(w16_in_ready), .oper(w16_oper), .a(w16_a), .b(w16_b),
      .out_valid(w16_out_valid), .result(w16_result), .hi(w16_hi), .lo(w16_lo),
      .busy(w16_busy)
   );

   // Present one op for exactly one edge; returns #1 after that edge.
   task automatic issue(input logic [4:0] op, input logic [31:0] aa, input logic [31:0] bb);
      oper = op; a = aa; b = bb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Cycles after accept until out_valid is seen (0 on timeout); counts in_ready-low samples.
   task automatic wait_done(output int lat, output int low_cnt);
      lat = 0;
      low_cnt = in_ready ? 0 : 1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (!in_ready) low_cnt++;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready: in_ready=%b busy=%b want 1/0", in_ready, busy); end
   endtask

   task automatic test_single();
      logic [4:0]  ops [10];
      logic [31:0] av [10];
      logic [31:0] bv [10];
      logic [31:0] ev [10];
      ops[0] = EXE_ALU_SLT;  av[0] = 32'hFFFFFFFF; bv[0] = 32'h1;        ev[0] = 32'h1;
      ops[1] = EXE_ALU_SLTU; av[1] = 32'hFFFFFFFF; bv[1] = 32'h1;        ev[1] = 32'h0;
      ops[2] = EXE_ALU_SRA;  av[2] = 32'h4;        bv[2] = 32'h80000000; ev[2] = 32'hF8000000;
      ops[3] = EXE_ALU_LUI;  av[3] = 32'h0;        bv[3] = 32'h00001234; ev[3] = 32'h12340000;
      ops[4] = EXE_ALU_ADD;  av[4] = 32'hFFFFFFFF; bv[4] = 32'h1;        ev[4] = 32'h0;
      ops[5] = EXE_ALU_SUB;  av[5] = 32'h0;        bv[5] = 32'h1;        ev[5] = 32'hFFFFFFFF;
      ops[6] = EXE_ALU_NOR;  av[6] = 32'h0F0F0000; bv[6] = 32'h00F0000F; ev[6] = 32'hF000FFF0;
      ops[7] = EXE_ALU_SRLV; av[7] = 32'h24;       bv[7] = 32'hF0000000; ev[7] = 32'h0F000000;
      ops[8] = EXE_ALU_SLLV; av[8] = 32'h3;        bv[8] = 32'h1;        ev[8] = 32'h8;
      ops[9] = 5'd31;        av[9] = 32'h5;        bv[9] = 32'h6;        ev[9] = 32'h0;
      // Issued back to back: each accept edge must produce its own result.
      for (int i = 0; i < 10; i++) begin
         issue(ops[i], av[i], bv[i]);
         checks++;
         if (out_valid !== 1'b1 || result !== ev[i]) begin
            errors++;
            $display("FAIL single[%0d] op=%0d: out_valid=%b result=%h want 1/%h", i, ops[i], out_valid, result, ev[i]);
         end
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_end: got %b want 0", out_valid); end
   endtask

   task automatic test_multu();
      int lat, low_cnt;
      issue(EXE_ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL multu_start: out_valid=%b busy=%b want 0/1", out_valid, busy); end
      wait_done(lat, low_cnt);
      checks++; if (lat != 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
      checks++; if (low_cnt != 33) begin errors++; $display("FAIL multu_ready_low: got %0d want 33", low_cnt); end
      checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin errors++; $display("FAIL multu_value: got %h_%h want fffffffe_00000001", hi, lo); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL multu_result_kept: got %h want 0", result); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL multu_pulse_end: got %b want 0", out_valid); end
   endtask

   task automatic test_div();
      int lat, low_cnt;
      issue(EXE_ALU_MULT, 32'hFFFFFFFD, 32'h5);
      wait_done(lat, low_cnt);
      checks++; if (lat != 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_neg: lat=%0d got %h_%h want 33 ffffffff_fffffff1", lat, hi, lo); end
      issue(EXE_ALU_DIV, 32'hFFFFFFF9, 32'h2);
      wait_done(lat, low_cnt);
      checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
      checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_value: lo=%h hi=%h want fffffffd/ffffffff", lo, hi); end
      issue(EXE_ALU_DIVU, 32'h7, 32'h0);
      wait_done(lat, low_cnt);
      checks++; if (lat != 33) begin errors++; $display("FAIL divu0_latency: got %0d want 33", lat); end
      checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'h7) begin errors++; $display("FAIL divu0_value: lo=%h hi=%h want ffffffff/7", lo, hi); end
   endtask

   task automatic test_flush();
      int pulses;
      pulses = 0;
      issue(EXE_ALU_MULT, 32'h3, 32'h5);
      repeat (9) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
      checks++; if (hi !== 32'h7 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_hilo: got %h/%h want 7/ffffffff", hi, lo); end
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL flush_no_pulse: got %0d pulses want 0", pulses); end
      issue(EXE_ALU_MFLO, 32'h0, 32'h0);
      checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_mflo: got %h want ffffffff", result); end
      // Flush while idle blocks acceptance.
      oper = EXE_ALU_MTHI; a = 32'h1234; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || hi !== 32'h7) begin errors++; $display("FAIL flush_blocks_accept: out_valid=%b hi=%h want 0/7", out_valid, hi); end
   endtask

   task automatic test_rst_mid();
      issue(EXE_ALU_DIV, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (hi !== 32'h0 || lo !== 32'h0 || result !== 32'h0) begin errors++; $display("FAIL rst_mid_regs: hi=%h lo=%h result=%h want 0", hi, lo, result); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
      issue(EXE_ALU_MTHI, 32'hA5A5A5A5, 32'h0);
      checks++; if (out_valid !== 1'b1 || hi !== 32'hA5A5A5A5 || result !== 32'h0) begin errors++; $display("FAIL mthi: out_valid=%b hi=%h result=%h want 1/a5a5a5a5/0", out_valid, hi, result); end
      issue(EXE_ALU_MFHI, 32'h0, 32'h0);
      checks++; if (result !== 32'hA5A5A5A5) begin errors++; $display("FAIL mfhi: got %h want a5a5a5a5", result); end
   endtask

   task automatic test_back_to_back();
      issue(EXE_ALU_MTLO, 32'h13579BDF, 32'h0);
      issue(EXE_ALU_MFLO, 32'h0, 32'h0);
      checks++; if (out_valid !== 1'b1 || result !== 32'h13579BDF) begin errors++; $display("FAIL mtlo_mflo: out_valid=%b result=%h want 1/13579bdf", out_valid, result); end
   endtask

   task automatic test_width16();
      int lat;
      lat = 0;
      w16_oper = EXE_ALU_MULT; w16_a = 16'h8000; w16_b = 16'h8000; w16_in_valid = 1'b1;
      @(posedge clk); #1;
      w16_in_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (w16_out_valid) begin
            lat = k;
            break;
         end
      end
      checks++; if (lat != 17) begin errors++; $display("FAIL w16_latency: got %0d want 17", lat); end
      checks++; if (w16_hi !== 16'h4000 || w16_lo !== 16'h0000) begin errors++; $display("FAIL w16_mult: got %h_%h want 4000_0000", w16_hi, w16_lo); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_multu();
      test_div();
      test_flush();
      test_rst_mid();
      test_back_to_back();
      test_width16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, registered successor to the EXE-stage ALU.
- Performs single-cycle integer ops and multicycle iterative MULT/MULTU/DIV/DIVU into an internal HI/LO pair.
- Uses a valid/ready handshake; busy stalls the pipeline while a multiply or divide is in flight.
- Sits in EXE; result feeds EXE/MEM; flush comes from the hazard unit.

Parameters:
- WIDTH, 32, operand/result width; even, at least 8.
- SHAMT_W, 5, shift-amount bits taken from a; must equal log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  abort in-flight multicycle op
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept (state IDLE)
- oper  in  5  operation code, EXE_ALU_* from shared package
- a  in  WIDTH  operand A / shift amount
- b  in  WIDTH  operand B / shifted value
- out_valid  out  1  one-cycle pulse: result (or HI/LO) updated
- result  out  WIDTH  registered result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  equals ~in_ready

Behaviour:
- Reset (rst=1 at an edge): state IDLE; result, hi, lo = 0; out_valid = 0; in_ready = 1; iteration counter = 0. Reset mid-operation discards the op; hi/lo are zeroed.
- Accept: in_valid && in_ready at edge N.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, LUI, MFHI, MFLO, MTHI, MTLO): result registered at edge N; out_valid=1 for cycle N..N+1; state stays IDLE, so back-to-back issue is allowed.
- Arithmetic rules: ADD/SUB wrap modulo 2^WIDTH, no overflow flag.
- SLT compares signed; SLTU compares unsigned; result is 1 or 0, zero-extended.
- Shift count = a[SHAMT_W-1:0]. SRA/SRAV replicate b[WIDTH-1].
- LUI: {b[WIDTH/2-1:0], WIDTH/2 zeros}.
- MFHI/MFLO: result = hi/lo.
- MTHI/MTLO: hi/lo = a at edge N; result unchanged.
- Unknown oper: result = 0, out_valid still pulses.
- Multicycle ops (MULT, MULTU, DIV, DIVU): FSM IDLE -> MUL or DIV -> FIX -> IDLE.
  - Accept edge N: latch |a| and |b| (signed ops) or a and b (unsigned ops) and the sign flags; counter = WIDTH.
  - MUL: shift-add, one bit per edge. DIV: restoring, one quotient bit per edge. Counter decrements each edge; exit to FIX when the counter reaches 1.
  - FIX (edge N+WIDTH+1): apply sign correction, write hi/lo, out_valid=1 for the following cycle, return to IDLE.
  - Total: out_valid high in cycle N+WIDTH+1..N+WIDTH+2; in_ready low from N until that edge.
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed quotient sign = a^b sign bit; remainder takes the sign of a (truncating division).
  - Divide by zero: same latency; lo = all ones, hi = a; no trap.
  - result is not modified by multicycle ops.
- Flush: when flush=1 in any non-IDLE state, return to IDLE at that edge; hi/lo unchanged; no out_valid.
  - flush in IDLE together with in_valid: the op is not accepted.
  - rst takes priority over flush.
- in_valid while busy: ignored and not queued; the producer holds it (standard handshake).

Decomposition:
- Shared package (define.vh / mips_define.vh): EXE_ALU_* 5-bit opcodes. Existing codes are kept; LUI gets its own distinct code; MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO are added.
- FSM state constants are local to the module.
- One sub-module, mdu_iter: iterative multiply/divide datapath, counter and sign fix. It takes a start/flush/kind input and returns done/hi/lo.
- The top level holds the single-cycle ALU, the HI/LO registers and the handshake.

Test Plan:
- Single-cycle ops, WIDTH=32: SLT a=0xFFFFFFFF, b=1 -> result=1. SLTU same operands -> 0. SRA a=4, b=0x80000000 -> 0xF8000000. LUI b=0x00001234 -> 0x12340000. Each out_valid occurs one cycle after accept.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. out_valid exactly 33 cycles after accept; in_ready low for 33 edges.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
- Issue MULT 3*5, assert flush at cycle 10 -> back to IDLE with no out_valid; hi/lo keep their prior values. Then MFLO returns the prior lo.
- rst asserted mid-DIV -> next cycle hi=lo=result=0, in_ready=1. Then MTHI a=0xA5A5A5A5 followed by MFHI -> result=0xA5A5A5A5.
- WIDTH=16 instance: MULT a=0x8000, b=0x8000 -> hi=0x4000, lo=0x0000, out_valid 17 cycles after accept.
